map_extent_lr: RTL and testbench
================================

MAP_EXTENT_LR -- requirements
Module: map_extent_lr

Interface
REQ-001 Parameter X_RES, default 60, image width in pixels.
REQ-002 Parameter Y_RES, default 60, image height in pixels.
REQ-003 Parameter XW, default 6, x coordinate width; SHALL satisfy 2**XW >= X_RES.
REQ-004 Parameter YW, default 6, y coordinate width; SHALL satisfy 2**YW >= Y_RES.
REQ-005 Parameter COL_W, default 3, pixel value width.
REQ-006 Parameter THRESHOLD, default 0; a pixel with value <= THRESHOLD is background.
REQ-007 Derived localparam ADDR_W = clog2(X_RES*Y_RES).
REQ-008 One clock; reset is synchronous and active-high. Ports: clk in 1, rising-edge clock; reset in 1.
REQ-009 start in 1: a one-cycle request, sampled only in IDLE.
REQ-010 most_top in YW, most_bottom in YW, mid_pix in XW: scan bounds, latched when start is accepted.
REQ-011 mem_rd_en out 1, mem_addr out ADDR_W: registered read request. mem_rd_data in COL_W is valid exactly one cycle after mem_rd_en.
REQ-012 busy out 1; done out 1 (one-cycle pulse); err out 1; valid out 1.
REQ-013 most_left out XW, most_right out XW: horizontal extent of the shape.

Function
REQ-014 FSM states: IDLE, ROW_INIT, L_REQ, L_WAIT, R_REQ, R_WAIT, NEXT_ROW, DONE.
REQ-015 IDLE with start=1 and legal bounds SHALL latch the inputs, set busy=1, clear valid/err, set most_left=most_right=mid_pix and y=most_top, then go to ROW_INIT.
REQ-016 Bounds are illegal if most_top > most_bottom, most_bottom >= Y_RES, or mid_pix >= X_RES. In that case: go directly to DONE with err=1, most_left=most_right=0.
REQ-017 ROW_INIT: x=mid_pix, go to L_REQ. L_REQ/R_REQ: mem_rd_en=1, mem_addr=y*X_RES+x, then go to the matching WAIT state.
REQ-018 L_WAIT with foreground data: most_left=min(most_left,x). If x==0, go to R_REQ with x=mid_pix; otherwise x=x-1 and go to L_REQ.
REQ-019 L_WAIT with background data: go to R_REQ with x=mid_pix; most_left is unchanged.
REQ-020 R_WAIT mirrors L_WAIT using max() and x+1, with boundary x==X_RES-1; it exits to NEXT_ROW.
REQ-021 NEXT_ROW goes to DONE if y==most_bottom, or if most_left==0 and most_right==X_RES-1 (early exit). Otherwise y=y+1 and go to ROW_INIT.
REQ-022 DONE: done=1 for one cycle, valid=1 unless err, busy=0, go to IDLE.
REQ-023 most_left, most_right, valid and err SHALL hold until the next accepted start.
REQ-024 Latency: done is high in cycle 1 + sum over rows of (2 + 2*nL + 2*nR) after the start edge, where nL and nR are the pixels read per row. Illegal bounds give done in cycle 2.
REQ-025 start while busy SHALL be ignored. Input changes while busy SHALL have no effect.
REQ-026 mem_rd_en SHALL be 0 in every state except L_REQ and R_REQ. x and y SHALL never leave [0,X_RES-1] and [0,Y_RES-1].
REQ-027 The mid pixel is read by both scans. A background mid pixel gives nL=nR=1 and leaves the extents at mid_pix.

Reset
REQ-028 While reset=1: state=IDLE, busy=done=err=valid=mem_rd_en=0, mem_addr=0, most_left=most_right=0.
REQ-029 Reset mid-scan SHALL abort with no done pulse. Any mem_rd_data arriving afterwards SHALL be ignored.

Structure
REQ-030 Package map_pkg holds the state encoding and the default X_RES, Y_RES and THRESHOLD constants.
REQ-031 One sub-module, xy_to_addr, parametrised by X_RES, computes y*X_RES+x combinationally.

Verification
REQ-032 Single row: top=bottom=5, mid=10, foreground x=8..12 -> most_left=8, most_right=12, nL=nR=4, done in cycle 19.
REQ-033 Diamond over rows 3..7, widest row x=4..15, mid=9 -> most_left=4, most_right=15, valid=1, err=0.
REQ-034 Full-width foreground row at top=0 with bottom=10 -> extents 0 and 59, early exit after row 0, no reads for y>0.
REQ-035 top=7, bottom=3 -> err=1, valid=0, done in cycle 2, mem_rd_en never asserted.
REQ-036 reset pulsed during R_WAIT -> all outputs 0 next cycle, no done. A new start then completes normally.
REQ-037 start re-pulsed while busy, and mid_pix changed mid-scan -> results identical to an undisturbed run.

Source files
------------

// File: rtl/map_pkg.sv
// Shared constants for the map_extent_lr block: default image geometry,
// background threshold and FSM state encoding.
package map_pkg;

  localparam int unsigned DEF_X_RES     = 60;
  localparam int unsigned DEF_Y_RES     = 60;
  localparam int unsigned DEF_THRESHOLD = 0;

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [ST_W-1:0] ST_ROW_INIT = 3'd1;
  localparam logic [ST_W-1:0] ST_L_REQ    = 3'd2;
  localparam logic [ST_W-1:0] ST_L_WAIT   = 3'd3;
  localparam logic [ST_W-1:0] ST_R_REQ    = 3'd4;
  localparam logic [ST_W-1:0] ST_R_WAIT   = 3'd5;
  localparam logic [ST_W-1:0] ST_NEXT_ROW = 3'd6;
  localparam logic [ST_W-1:0] ST_DONE     = 3'd7;

endpackage

// File: rtl/map_extent_lr_if.sv
// Request, memory-read and result signals of map_extent_lr bundled as one bus.
// master = requester plus image memory, slave = the extent scanner.
interface map_extent_lr_if #(
  parameter int unsigned XW     = 6,
  parameter int unsigned YW     = 6,
  parameter int unsigned COL_W  = 3,
  parameter int unsigned ADDR_W = 12
);

  logic              start;
  logic [YW-1:0]     most_top;
  logic [YW-1:0]     most_bottom;
  logic [XW-1:0]     mid_pix;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [COL_W-1:0]  mem_rd_data;

  logic              busy;
  logic              done;
  logic              err;
  logic              valid;
  logic [XW-1:0]     most_left;
  logic [XW-1:0]     most_right;

  modport master (
    output start, most_top, most_bottom, mid_pix, mem_rd_data,
    input  mem_rd_en, mem_addr, busy, done, err, valid, most_left, most_right
  );

  modport slave (
    input  start, most_top, most_bottom, mid_pix, mem_rd_data,
    output mem_rd_en, mem_addr, busy, done, err, valid, most_left, most_right
  );

endinterface

// File: rtl/xy_to_addr.sv
// Row-major pixel address: y*X_RES + x, purely combinational.
module xy_to_addr #(
  parameter int unsigned X_RES  = 60,
  parameter int unsigned XW     = 6,
  parameter int unsigned YW     = 6,
  parameter int unsigned ADDR_W = 12
) (
  input  logic [XW-1:0]     x,
  input  logic [YW-1:0]     y,
  output logic [ADDR_W-1:0] addr_c
);

  assign addr_c = ADDR_W'(y) * ADDR_W'(X_RES) + ADDR_W'(x);

endmodule

// File: rtl/map_extent_lr.sv
// Scans rows most_top..most_bottom outward from mid_pix and reports the
// leftmost/rightmost foreground columns of the shape through the bus.
module map_extent_lr
  import map_pkg::*;
#(
  parameter int unsigned X_RES     = DEF_X_RES,
  parameter int unsigned Y_RES     = DEF_Y_RES,
  parameter int unsigned XW        = 6,
  parameter int unsigned YW        = 6,
  parameter int unsigned COL_W     = 3,
  parameter int unsigned THRESHOLD = DEF_THRESHOLD
) (
  input  logic           clk,
  input  logic           reset,
  map_extent_lr_if.slave bus
);

  localparam int unsigned     ADDR_W = $clog2(X_RES * Y_RES);
  localparam logic [XW-1:0]   X_LAST = XW'(X_RES - 1);
  localparam logic [COL_W-1:0] BG_MAX = COL_W'(THRESHOLD);

  logic [ST_W-1:0]   state, state_n;
  logic [XW-1:0]     x, x_n;
  logic [YW-1:0]     y, y_n;
  logic [XW-1:0]     mid, mid_n;
  logic [YW-1:0]     bottom, bottom_n;
  logic              bad, bad_n;
  logic [XW-1:0]     left, left_n;
  logic [XW-1:0]     right, right_n;
  logic              busy, busy_n;
  logic              done, done_n;
  logic              err, err_n;
  logic              valid, valid_n;
  logic              rd_en, rd_en_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [ADDR_W-1:0] calc_addr;
  logic              fg;
  logic              bounds_bad;

  assign fg         = bus.mem_rd_data > BG_MAX;
  assign bounds_bad = (bus.most_top > bus.most_bottom)
                   || (32'(bus.most_bottom) >= Y_RES)
                   || (32'(bus.mid_pix) >= X_RES);

  // Address of the pixel the next request will read.
  xy_to_addr #(
    .X_RES  (X_RES),
    .XW     (XW),
    .YW     (YW),
    .ADDR_W (ADDR_W)
  ) u_xy_to_addr (
    .x      (x_n),
    .y      (y_n),
    .addr_c (calc_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      x      <= '0;
      y      <= '0;
      mid    <= '0;
      bottom <= '0;
      bad    <= 1'b0;
      left   <= '0;
      right  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      valid  <= 1'b0;
      rd_en  <= 1'b0;
      addr   <= '0;
    end else begin
      state  <= state_n;
      x      <= x_n;
      y      <= y_n;
      mid    <= mid_n;
      bottom <= bottom_n;
      bad    <= bad_n;
      left   <= left_n;
      right  <= right_n;
      busy   <= busy_n;
      done   <= done_n;
      err    <= err_n;
      valid  <= valid_n;
      rd_en  <= rd_en_n;
      addr   <= addr_n;
    end
  end

  // Illegal bounds are flagged at start and retired from ROW_INIT before any read.
  always_comb begin
    state_n  = state;
    x_n      = x;
    y_n      = y;
    mid_n    = mid;
    bottom_n = bottom;
    bad_n    = bad;
    left_n   = left;
    right_n  = right;
    busy_n   = busy;
    done_n   = 1'b0;
    err_n    = err;
    valid_n  = valid;
    rd_en_n  = 1'b0;
    addr_n   = addr;

    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          mid_n    = bus.mid_pix;
          bottom_n = bus.most_bottom;
          bad_n    = bounds_bad;
          busy_n   = 1'b1;
          valid_n  = 1'b0;
          err_n    = 1'b0;
          left_n   = bounds_bad ? '0 : bus.mid_pix;
          right_n  = bounds_bad ? '0 : bus.mid_pix;
          y_n      = bounds_bad ? '0 : bus.most_top;
          state_n  = ST_ROW_INIT;
        end
      end

      ST_ROW_INIT: begin
        if (bad) begin
          err_n   = 1'b1;
          state_n = ST_DONE;
        end else begin
          x_n     = mid;
          state_n = ST_L_REQ;
        end
      end

      ST_L_REQ: state_n = ST_L_WAIT;

      ST_L_WAIT: begin
        if (fg) begin
          if (x < left) left_n = x;
          if (x == '0) begin
            x_n     = mid;
            state_n = ST_R_REQ;
          end else begin
            x_n     = x - XW'(1);
            state_n = ST_L_REQ;
          end
        end else begin
          x_n     = mid;
          state_n = ST_R_REQ;
        end
      end

      ST_R_REQ: state_n = ST_R_WAIT;

      ST_R_WAIT: begin
        if (fg) begin
          if (x > right) right_n = x;
          if (x == X_LAST) begin
            state_n = ST_NEXT_ROW;
          end else begin
            x_n     = x + XW'(1);
            state_n = ST_R_REQ;
          end
        end else begin
          state_n = ST_NEXT_ROW;
        end
      end

      // A full-width extent cannot grow further, so the remaining rows are skipped.
      ST_NEXT_ROW: begin
        if ((y == bottom) || ((left == '0) && (right == X_LAST))) begin
          state_n = ST_DONE;
        end else begin
          y_n     = y + YW'(1);
          state_n = ST_ROW_INIT;
        end
      end

      ST_DONE: state_n = ST_IDLE;

      default: state_n = ST_IDLE;
    endcase

    if (state_n == ST_DONE) begin
      done_n  = 1'b1;
      busy_n  = 1'b0;
      valid_n = ~err_n;
    end

    if ((state_n == ST_L_REQ) || (state_n == ST_R_REQ)) begin
      rd_en_n = 1'b1;
      addr_n  = calc_addr;
    end
  end

  assign bus.mem_rd_en  = rd_en;
  assign bus.mem_addr   = addr;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.err        = err;
  assign bus.valid      = valid;
  assign bus.most_left  = left;
  assign bus.most_right = right;

endmodule

// File: tb/tb_map_extent_lr.sv
// Directed bench for map_extent_lr: table of scan vectors over a behavioural
// image memory, plus reset-during-scan and reset-state sequences.
module tb_map_extent_lr;

  localparam int unsigned X_RES  = 60;
  localparam int unsigned Y_RES  = 60;
  localparam int unsigned XW     = 6;
  localparam int unsigned YW     = 6;
  localparam int unsigned COL_W  = 3;
  localparam int unsigned ADDR_W = 12;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  map_extent_lr_if #(.XW(XW), .YW(YW), .COL_W(COL_W), .ADDR_W(ADDR_W)) bus ();

  map_extent_lr #(
    .X_RES     (X_RES),
    .Y_RES     (Y_RES),
    .XW        (XW),
    .YW        (YW),
    .COL_W     (COL_W),
    .THRESHOLD (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Image memory: one-cycle read latency, garbage (all ones) when not reading.
  logic [COL_W-1:0] img [0:4095];
  int rd_total   = 0;
  int oow_total  = 0;
  int done_total = 0;
  int win_lo     = 0;
  int win_hi     = 4095;

  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      bus.mem_rd_data <= img[bus.mem_addr];
      rd_total        <= rd_total + 1;
      if (int'(bus.mem_addr) < win_lo || int'(bus.mem_addr) > win_hi)
        oow_total <= oow_total + 1;
    end else begin
      bus.mem_rd_data <= '1;
    end
    if (bus.done === 1'b1) done_total <= done_total + 1;
  end

  typedef struct {
    int top;
    int bottom;
    int mid;
    int shape;
    int last_row;
    int exp_left;
    int exp_right;
    int exp_err;
    int exp_lat;
    int exp_reads;
    bit disturb;
  } vec_t;

  vec_t vecs [10];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_row(input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) img[y*X_RES + x] = COL_W'(((x + y) % 7) + 1);
  endtask

  task automatic fill(input int shape);
    for (int i = 0; i < 4096; i++) img[i] = '0;
    case (shape)
      1: set_row(5, 8, 12);
      2: begin
        set_row(3, 8, 10);
        set_row(4, 6, 12);
        set_row(5, 4, 15);
        set_row(6, 6, 12);
        set_row(7, 8, 10);
      end
      3: begin
        set_row(0, 0, 59);
        set_row(1, 0, 59);
      end
      5: set_row(10, 0, 3);
      6: set_row(12, 57, 59);
      default: ;
    endcase
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   cyc;
    int   rd0;
    int   oow0;
    int   dn0;
    bit   seen;
    v = vecs[i];
    fill(v.shape);
    win_lo = v.top * X_RES;
    win_hi = (v.last_row + 1) * X_RES - 1;
    @(negedge clk);
    bus.most_top    = YW'(v.top);
    bus.most_bottom = YW'(v.bottom);
    bus.mid_pix     = XW'(v.mid);
    bus.start       = 1'b1;
    rd0  = rd_total;
    oow0 = oow_total;
    dn0  = done_total;
    @(posedge clk);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check($sformatf("v%0d busy_after_start", i), 32'(bus.busy), 32'd1);
      if (bus.done === 1'b1) begin
        seen      = 1'b1;
        bus.start = 1'b0;
      end else if (v.disturb) begin
        bus.start       = 1'($urandom);
        bus.mid_pix     = XW'($urandom);
        bus.most_top    = YW'($urandom);
        bus.most_bottom = YW'($urandom);
      end else begin
        bus.start = 1'b0;
      end
    end
    check($sformatf("v%0d done_seen", i), 32'(seen), 32'd1);
    if (!seen) return;
    check($sformatf("v%0d latency", i), 32'(cyc), 32'(v.exp_lat));
    check($sformatf("v%0d most_left", i), 32'(bus.most_left), 32'(v.exp_left));
    check($sformatf("v%0d most_right", i), 32'(bus.most_right), 32'(v.exp_right));
    check($sformatf("v%0d err", i), 32'(bus.err), 32'(v.exp_err));
    check($sformatf("v%0d valid", i), 32'(bus.valid), 32'(v.exp_err == 0));
    check($sformatf("v%0d busy_at_done", i), 32'(bus.busy), 32'd0);
    @(negedge clk);
    check($sformatf("v%0d done_one_cycle", i), 32'(bus.done), 32'd0);
    check($sformatf("v%0d left_held", i), 32'(bus.most_left), 32'(v.exp_left));
    check($sformatf("v%0d valid_held", i), 32'(bus.valid), 32'(v.exp_err == 0));
    check($sformatf("v%0d reads", i), 32'(rd_total - rd0), 32'(v.exp_reads));
    check($sformatf("v%0d reads_outside_rows", i), 32'(oow_total - oow0), 32'd0);
    check($sformatf("v%0d done_pulses", i), 32'(done_total - dn0), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"},       32'(bus.busy),       32'd0);
    check({tag, " done"},       32'(bus.done),       32'd0);
    check({tag, " err"},        32'(bus.err),        32'd0);
    check({tag, " valid"},      32'(bus.valid),      32'd0);
    check({tag, " mem_rd_en"},  32'(bus.mem_rd_en),  32'd0);
    check({tag, " mem_addr"},   32'(bus.mem_addr),   32'd0);
    check({tag, " most_left"},  32'(bus.most_left),  32'd0);
    check({tag, " most_right"}, 32'(bus.most_right), 32'd0);
  endtask

  initial begin
    int dn0;
    //          top bot mid shp last  L   R  err lat reads dist
    vecs[0] = '{ 5,  5, 10, 1,  5,   8, 12, 0,  19,  8, 1'b0};
    vecs[1] = '{ 3,  7,  9, 2,  7,   4, 15, 0, 105, 47, 1'b0};
    vecs[2] = '{ 0, 10, 30, 3,  0,   0, 59, 0, 125, 61, 1'b0};
    vecs[3] = '{ 7,  3, 10, 0,  0,   0,  0, 1,   2,  0, 1'b0};
    vecs[4] = '{ 0, 60,  5, 0,  0,   0,  0, 1,   2,  0, 1'b0};
    vecs[5] = '{ 0,  0, 60, 0,  0,   0,  0, 1,   2,  0, 1'b0};
    vecs[6] = '{20, 20, 30, 0, 20,  30, 30, 0,   7,  2, 1'b0};
    vecs[7] = '{10, 10,  0, 5, 10,   0,  3, 0,  15,  6, 1'b0};
    vecs[8] = '{12, 12, 59, 6, 12,  57, 59, 0,  13,  5, 1'b0};
    vecs[9] = '{ 3,  7,  9, 2,  7,   4, 15, 0, 105, 47, 1'b1};

    fill(0);
    reset           = 1'b1;
    bus.start       = 1'b1;
    bus.most_top    = YW'(2);
    bus.most_bottom = YW'(9);
    bus.mid_pix     = XW'(17);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset     = 1'b0;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(i);

    // Reset pulsed while the right scan of row 5 is waiting for data.
    fill(1);
    win_lo = 0;
    win_hi = 4095;
    @(negedge clk);
    bus.most_top    = YW'(5);
    bus.most_bottom = YW'(5);
    bus.mid_pix     = XW'(10);
    bus.start       = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("pre_reset busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("mid_scan_reset");
    reset = 1'b0;
    dn0   = done_total;
    repeat (30) @(negedge clk);
    check("after_abort done_pulses", 32'(done_total - dn0), 32'd0);
    check("after_abort busy", 32'(bus.busy), 32'd0);
    check("after_abort valid", 32'(bus.valid), 32'd0);
    run_vec(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
